mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one 4x4 shift-add multiplier core (START/READY/P handshake) among NREQ requesters.
- Arbitrates round-robin and registers the winner's operands, holding them stable on the core inputs.
- Pulses START, waits for READY and returns the 8-bit product with a one-cycle ACK.
- Sits between requesting datapath blocks and the multiplier core; a timeout watchdog flags a hung core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 15, maximum WAIT cycles before abort (1..255).

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NREQ  per-requester request level; held until ACK.
- A_IN  in  4*NREQ  multiplicands; requester i uses bits [4i+3:4i]; stable while REQ[i] is high.
- B_IN  in  4*NREQ  multipliers; same packing as A_IN.
- GNT  out  NREQ  one-hot; high for the winner from grant until ACK.
- ACK  out  NREQ  one-hot, one-cycle pulse; PROD valid in the same cycle.
- PROD  out  8  registered product; holds its value until the next ACK.
- ERR  out  1  sticky timeout flag; cleared only by RST.
- MSTART  out  1  core START, one-cycle pulse.
- MA  out  4  core A operand, registered, stable from LAUNCH through DONE.
- MB  out  4  core B operand, same timing as MA.
- MREADY  in  1  core READY.
- MP  in  8  core product {P7..P0}.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE, rr_ptr=0, timer=0.
  - GNT, ACK, PROD, MSTART, MA, MB and ERR all go to 0.
  - A reset mid-operation abandons the current transaction with no ACK; the core is restarted by the next LAUNCH.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - If REQ is nonzero, pick the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Register the winner index, GNT=onehot(winner), MA=A_IN[winner], MB=B_IN[winner]; go to LAUNCH.
  - If REQ is zero, stay in IDLE.
- LAUNCH: MSTART=1 for exactly this cycle; timer=0; go to WAIT.
- WAIT:
  - MREADY is ignored in the first WAIT cycle, because it may still be high from the previous product.
  - From the second cycle on, if MREADY=1: PROD<=MP, go to DONE.
  - Otherwise timer increments. When timer==TIMEOUT: ERR<=1, PROD<=8'h00, go to DONE.
- DONE:
  - ACK[winner]=REQ[winner], so a requester that dropped REQ early gets no ACK and its result is discarded.
  - rr_ptr<=(winner+1) mod NREQ; GNT<=0; go to IDLE.
  - rr_ptr advances even if the ACK was suppressed.
- Throughput: minimum of 1 IDLE + 1 LAUNCH + 2 WAIT + 1 DONE cycles per transaction. A new request is picked on the first IDLE cycle after DONE.
- Simultaneous requests: exactly one grant per transaction. Losers keep REQ high; no request is starved for more than NREQ-1 transactions.
- New REQ bits arriving during LAUNCH, WAIT or DONE are not considered until IDLE.
- Operands are captured only in IDLE. Changes on A_IN/B_IN after capture have no effect.
- Arithmetic is unsigned. The product width is 8 bits, with no truncation (15*15=225 fits).
- NREQ not a power of two: the rr_ptr wrap uses explicit compare, not bit truncation.

Decomposition:
- Package mul_share_pkg holds:
  - OPW=4 and PW=8;
  - the state enum {IDLE, LAUNCH, WAIT, DONE};
  - the timer width localparam, $clog2(TIMEOUT+1).
- One sub-module, rr_pick: combinational round-robin one-hot picker with inputs (req, ptr) and outputs (onehot, idx, any). It is parameterised by NREQ and unit-testable on its own.

Test Plan:
- Single request, real core: REQ=4'b0001, A_IN[3:0]=3, B_IN[3:0]=5 -> one MSTART pulse, then ACK=4'b0001 for one cycle, PROD=8'h0F, GNT[0] high from grant until ACK, ERR=0.
- Max operands: requester 2 sends 15*15 -> PROD=8'hE1. Requester 1 sends 0*9 -> PROD=8'h00.
- Contention: REQ=4'b1111 held, each requester i sends operands (i+1, i+2) -> ACK order 0,1,2,3,0, with PROD 0x02,0x06,0x0C,0x14,0x02. Exactly one GNT bit set at any time.
- Timeout: core model with MREADY stuck 0, TIMEOUT=15 -> ACK 16 WAIT cycles after MSTART, PROD=0, ERR=1 and staying 1 through later good transactions until RST.
- Early drop: REQ[1] deasserted during WAIT -> no ACK, rr_ptr advances to 2, next pending REQ[2] is served next.
- Reset mid-WAIT: RST=1 for one cycle -> GNT/ACK/MSTART/PROD/ERR=0 next cycle. A subsequent request completes correctly with a fresh MSTART.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int unsigned OPW = 4;  // operand width
    localparam int unsigned PW  = 8;  // product width

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } state_e;

    // Timer width able to hold the value TIMEOUT.
    function automatic int unsigned tmr_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         onehot_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);
    localparam int unsigned IW     = $clog2(NREQ);
    localparam logic [IW:0] NREQ_W = NREQ[IW:0];

    // Scan upward from ptr; the wrap is an explicit compare so non-power-of-two NREQ works.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_i} + k[IW:0];
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[IW-1:0];
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one START/READY multiplier core among NREQ requesters, round-robin, with a
// watchdog that aborts a transaction when the core never answers.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                CK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ,
    input  logic [OPW*NREQ-1:0] A_IN,
    input  logic [OPW*NREQ-1:0] B_IN,
    output logic [NREQ-1:0]     GNT,
    output logic [NREQ-1:0]     ACK,
    output logic [PW-1:0]       PROD,
    output logic                ERR,
    output logic                MSTART,
    output logic [OPW-1:0]      MA,
    output logic [OPW-1:0]      MB,
    input  logic                MREADY,
    input  logic [PW-1:0]       MP
);
    localparam int unsigned   IW    = $clog2(NREQ);
    localparam int unsigned   TW    = tmr_width(TIMEOUT);
    localparam int unsigned   LASTI = NREQ - 1;
    localparam logic [IW-1:0] LAST  = LASTI[IW-1:0];
    localparam logic [TW-1:0] TMAX  = TIMEOUT[TW-1:0];

    state_e        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] winner_q, winner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [OPW-1:0] ma_q, ma_d, mb_q, mb_d;
    logic [PW-1:0] prod_q, prod_d;
    logic          err_q, err_d;
    logic          mstart_q, mstart_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [NREQ-1:0] ack;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [OPW-1:0]  a_arr [NREQ];
    logic [OPW-1:0]  b_arr [NREQ];

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req_i   (REQ),
        .ptr_i   (rr_ptr_q),
        .onehot_o(pick_onehot),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Unpack the flat operand buses so the winner can be selected by index.
    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            a_arr[k] = A_IN[k*OPW +: OPW];
            b_arr[k] = B_IN[k*OPW +: OPW];
        end
    end

    // Next-state and output decode for the IDLE/LAUNCH/WAIT/DONE sequence.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        gnt_d    = gnt_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        prod_d   = prod_q;
        err_d    = err_q;
        timer_d  = timer_q;
        mstart_d = 1'b0;
        ack      = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    winner_d = pick_idx;
                    gnt_d    = pick_onehot;
                    ma_d     = a_arr[pick_idx];
                    mb_d     = b_arr[pick_idx];
                    mstart_d = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // timer_q==0 marks the first WAIT cycle, where READY may be stale.
                if (timer_q != '0 && MREADY) begin
                    prod_d  = MP;
                    state_d = DONE;
                end else if (timer_q == TMAX) begin
                    err_d   = 1'b1;
                    prod_d  = '0;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                // A requester that dropped REQ early is not acknowledged.
                ack      = gnt_q & REQ;
                rr_ptr_d = (winner_q == LAST) ? '0 : winner_q + 1'b1;
                gnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            gnt_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            prod_q   <= '0;
            err_q    <= 1'b0;
            mstart_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
            mstart_q <= mstart_d;
            timer_q  <= timer_d;
        end
    end

    assign GNT    = gnt_q;
    assign ACK    = ack;
    assign PROD   = prod_q;
    assign ERR    = err_q;
    assign MSTART = mstart_q;
    assign MA     = ma_q;
    assign MB     = mb_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a behavioural multiplier core model.
module tb_mul_share_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic            CK = 1'b0;
    logic            RST = 1'b1;
    logic [NREQ-1:0] REQ = '0;
    logic [4*NREQ-1:0] A_IN = '0, B_IN = '0;
    logic [NREQ-1:0] GNT, ACK;
    logic [7:0]      PROD;
    logic            ERR, MSTART;
    logic [3:0]      MA, MB;
    logic            MREADY = 1'b0;
    logic [7:0]      MP = '0;

    mul_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CK(CK), .RST(RST), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN), .GNT(GNT), .ACK(ACK),
        .PROD(PROD), .ERR(ERR), .MSTART(MSTART), .MA(MA), .MB(MB), .MREADY(MREADY), .MP(MP)
    );

    always #5 CK = ~CK;

    int n_checks = 0, n_fail = 0, cyc = 0;
    logic [7:0] exp_q [NREQ][$];
    int ack_log [$];
    int ack_cnt [NREQ], seen_cnt [NREQ];
    bit [NREQ-1:0] rerq_pend = '0;
    bit auto_rerq = 0, rand_on = 0, stuck = 0;
    logic [3:0] fixed_a [NREQ], fixed_b [NREQ];
    int core_lat_lo = 0, core_lat_hi = 3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_first(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int c = (p + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Core model: latches operands on START, answers after a random delay; READY stays
    // high (stale) into the first cycle after a new START.
    logic [3:0] c_a = '0, c_b = '0;
    int c_cnt = 0;
    bit c_busy = 0;
    always @(posedge CK) begin
        if (MSTART) begin
            c_a <= MA; c_b <= MB; c_busy <= 1'b1;
            c_cnt <= $urandom_range(core_lat_hi, core_lat_lo);
        end else if (c_busy) begin
            if (c_cnt == 0) begin
                c_busy <= 1'b0;
                MREADY <= 1'b1;
                MP <= 8'(c_a) * 8'(c_b);
            end else begin
                c_cnt <= c_cnt - 1;
                MREADY <= 1'b0;
            end
        end
        if (stuck) begin
            MREADY <= 1'b0;
            MP <= 8'($urandom);
        end
    end

    // Monitor: reference arbitration model plus scoreboard pops on ACK.
    initial begin
        int m_ptr = 0, cur_win = 0, gnt_cyc = 0, w;
        bit in_txn = 0, exp_err = 0, post_rst = 0, gnt_rise;
        logic [NREQ-1:0] gnt_prev = '0, prev_req = '0;
        logic [3:0] prev_a [NREQ], prev_b [NREQ];
        logic [3:0] cap_a = '0, cap_b = '0;
        logic [7:0] e;
        forever begin
            @(negedge CK);
            cyc++;
            if (RST) begin
                m_ptr = 0; exp_err = 0; in_txn = 0; post_rst = 1;
            end else begin
                if (post_rst) begin
                    chk("rst_gnt", GNT, 0);     chk("rst_ack", ACK, 0);
                    chk("rst_mstart", MSTART, 0); chk("rst_prod", PROD, 0);
                    chk("rst_err", ERR, 0);     chk("rst_ma", MA, 0);
                    chk("rst_mb", MB, 0);
                    post_rst = 0;
                end
                gnt_rise = (GNT != 0) && (gnt_prev == 0);
                chk("gnt_onehot", $onehot0(GNT), 1);
                chk("mstart_pulse", MSTART, gnt_rise);
                if (gnt_rise) begin
                    w = rr_first(prev_req, m_ptr);
                    if (w < 0) chk("grant_spurious", GNT, 0);
                    else begin
                        chk("grant_winner", GNT, 32'(1) << w);
                        chk("ma_capture", MA, prev_a[w]);
                        chk("mb_capture", MB, prev_b[w]);
                        cap_a = prev_a[w]; cap_b = prev_b[w];
                        m_ptr = (w + 1 == NREQ) ? 0 : w + 1;
                        cur_win = w; gnt_cyc = cyc; in_txn = 1;
                    end
                end else if (in_txn && GNT != 0) begin
                    chk("gnt_hold", GNT, 32'(1) << cur_win);
                    chk("ma_hold", MA, cap_a);
                    chk("mb_hold", MB, cap_b);
                end
                if (ACK != 0) begin
                    chk("ack_in_txn", in_txn, 1);
                    chk("ack_who", ACK, 32'(1) << cur_win);
                    if (stuck) begin
                        exp_err = 1;
                        chk("timeout_latency", cyc - gnt_cyc, TIMEOUT + 2);
                    end else begin
                        chk("ack_latency_min", (cyc - gnt_cyc) >= 3, 1);
                    end
                    chk("ack_expected", exp_q[cur_win].size() > 0, 1);
                    if (exp_q[cur_win].size() > 0) begin
                        e = exp_q[cur_win].pop_front();
                        chk("prod", PROD, e);
                    end
                    ack_cnt[cur_win]++;
                    ack_log.push_back(cur_win);
                end
                chk("err", ERR, exp_err);
                if (GNT == 0 && gnt_prev != 0) in_txn = 0;
            end
            gnt_prev = GNT; prev_req = REQ;
            for (int i = 0; i < NREQ; i++) begin
                prev_a[i] = A_IN[i*4 +: 4];
                prev_b[i] = B_IN[i*4 +: 4];
            end
        end
    end

    // Stimulus: issuing a request pushes its expected product.
    task automatic raise(input int i, input logic [3:0] a, input logic [3:0] b);
        A_IN[i*4 +: 4] = a;
        B_IN[i*4 +: 4] = b;
        REQ[i] = 1'b1;
        exp_q[i].push_back(stuck ? 8'h00 : 8'(a) * 8'(b));
    endtask

    task automatic step();
        @(posedge CK); #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i] = ack_cnt[i];
                REQ[i] = 1'b0;
                rerq_pend[i] = auto_rerq;
            end else if (!REQ[i] && rerq_pend[i]) begin
                rerq_pend[i] = 1'b0;
                raise(i, fixed_a[i], fixed_b[i]);
            end else if (!REQ[i] && rand_on) begin
                if ($urandom_range(3, 0) == 0) raise(i, 4'($urandom), 4'($urandom));
                else begin
                    A_IN[i*4 +: 4] = 4'($urandom);
                    B_IN[i*4 +: 4] = 4'($urandom);
                end
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (!(REQ == 0 && GNT == 0 && rerq_pend == 0) && k < 800) begin
            step(); k++;
        end
        chk("drain_done", (REQ == 0 && GNT == 0), 1);
    endtask

    task automatic wait_mstart();
        int k = 0;
        while (!MSTART && k < 100) begin
            step(); k++;
        end
        chk("mstart_seen", MSTART, 1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < NREQ; i++) begin ack_cnt[i] = 0; seen_cnt[i] = 0; end
        step(); step();
        RST = 1'b0;
        step();

        // Contention: all four held, operands (i+1, i+2).
        for (int i = 0; i < NREQ; i++) begin
            fixed_a[i] = 4'(i + 1); fixed_b[i] = 4'(i + 2);
        end
        ack_log.delete();
        auto_rerq = 1;
        for (int i = 0; i < NREQ; i++) raise(i, fixed_a[i], fixed_b[i]);
        k = 0;
        while (ack_log.size() < 5 && k < 300) begin step(); k++; end
        auto_rerq = 0;
        chk("contention_acks", ack_log.size() >= 5, 1);
        if (ack_log.size() >= 5) begin
            chk("order0", ack_log[0], 0); chk("order1", ack_log[1], 1);
            chk("order2", ack_log[2], 2); chk("order3", ack_log[3], 3);
            chk("order4", ack_log[4], 0);
        end
        drain();

        // Single request and operand extremes.
        raise(0, 4'd3, 4'd5);  drain(); chk("prod_hold_0f", PROD, 8'h0F);
        raise(2, 4'd15, 4'd15); drain(); chk("prod_hold_e1", PROD, 8'hE1);
        raise(1, 4'd0, 4'd9);  drain(); chk("prod_hold_00", PROD, 8'h00);
        chk("err_clean", ERR, 0);

        // Timeout with a silent core, then a good transaction with ERR still set.
        stuck = 1;
        raise(3, 4'd7, 4'd9); drain();
        stuck = 0;
        chk("err_set", ERR, 1);
        raise(0, 4'd6, 4'd7); drain();
        chk("err_sticky", ERR, 1);

        // Early drop: REQ[1] leaves during WAIT, then comes back on the next IDLE cycle.
        ack_log.delete();
        raise(1, 4'd4, 4'd4); raise(2, 4'd5, 4'd3);
        wait_mstart();
        step();
        REQ[1] = 1'b0; exp_q[1].delete();
        k = 0;
        while (GNT != 0 && k < 100) begin step(); k++; end
        raise(1, 4'd2, 4'd11);
        drain();
        chk("drop_count", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            chk("drop_first", ack_log[0], 2); chk("drop_second", ack_log[1], 1);
        end

        // Reset during WAIT; the held request must then complete afresh.
        core_lat_lo = 6; core_lat_hi = 6;
        ack_log.delete();
        raise(0, 4'd13, 4'd11);
        wait_mstart();
        step(); step();
        RST = 1'b1; step(); RST = 1'b0;
        drain();
        chk("rst_retry_count", ack_log.size(), 1);
        core_lat_lo = 0; core_lat_hi = 4;

        // Random traffic.
        rand_on = 1;
        repeat (800) step();
        rand_on = 0;
        drain();
        for (int i = 0; i < NREQ; i++) chk("queue_empty", exp_q[i].size(), 0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
